// File: rtl/term_loopback_pipe.sv
// Terminal-tile loopback: returns S_END wire groups to N_BEG bit-reversed, with each channel
// independently combinational, delayed by a programmable depth, or tied off.
module term_loopback_pipe #(
   parameter int NUM_CH    = 4,
   parameter int WIDTH     = 16,
   parameter int MAX_DEPTH = 4
) (
   input  logic                    UserCLK,
   input  logic                    reset,
   input  logic                    ConfigEn,
   input  logic                    ConfigIn,
   input  logic                    ConfigLatch,
   output logic                    ConfigOut,
   input  logic [NUM_CH*WIDTH-1:0] S_END,
   output logic [NUM_CH*WIDTH-1:0] N_BEG
);
   localparam int DW = $clog2(MAX_DEPTH);
   localparam int F  = 2 + DW;
   localparam int L  = NUM_CH * F;

   localparam logic [1:0] MODE_COMB = 2'd0;
   localparam logic [1:0] MODE_PIPE = 2'd1;
   localparam logic [1:0] MODE_TIE0 = 2'd2;
   localparam logic [1:0] MODE_TIE1 = 2'd3;

   function automatic logic [WIDTH-1:0] rev_bits(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      r = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = x[WIDTH-1-i];
      end
      return r;
   endfunction

   logic [L-1:0] shadow_r;
   logic [L-1:0] active_r;

   // Shadow chain: shifts toward bit 0 while enabled, bit 0 feeds the daisy chain.
   always_ff @(posedge UserCLK) begin
      if (reset) begin
         shadow_r <= {L{1'b0}};
      end else if (ConfigEn) begin
         shadow_r <= {ConfigIn, shadow_r[L-1:1]};
      end else begin
         shadow_r <= shadow_r;
      end
   end

   // Active config: on commit it takes the shadow as it stood before this edge's shift.
   always_ff @(posedge UserCLK) begin
      if (reset) begin
         active_r <= {L{1'b0}};
      end else if (ConfigLatch) begin
         active_r <= shadow_r;
      end else begin
         active_r <= active_r;
      end
   end

   assign ConfigOut = shadow_r[0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [1:0]       mode_s;
      logic [DW-1:0]    depth_s;
      logic             flush_s;
      logic [WIDTH-1:0] rev_s;
      logic [WIDTH-1:0] out_s;
      logic [WIDTH-1:0] line_r [MAX_DEPTH];

      // Field decode; a commit that changes this channel's field flushes its delay line.
      always_comb begin
         mode_s  = active_r[c*F +: 2];
         depth_s = active_r[c*F+2 +: DW];
         rev_s   = rev_bits(S_END[c*WIDTH +: WIDTH]);
         if (ConfigLatch && (shadow_r[c*F +: F] != active_r[c*F +: F])) begin
            flush_s = 1'b1;
         end else begin
            flush_s = 1'b0;
         end
      end

      // Delay line: stage k holds the reversed input from k+1 cycles ago.
      always_ff @(posedge UserCLK) begin
         if (reset || flush_s) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
               line_r[k] <= {WIDTH{1'b0}};
            end
         end else begin
            line_r[0] <= rev_s;
            for (int k = 1; k < MAX_DEPTH; k++) begin
               line_r[k] <= line_r[k-1];
            end
         end
      end

      // Output select; PIPE mode drives straight from a delay-line register.
      always_comb begin
         case (mode_s)
            MODE_COMB: out_s = rev_s;
            MODE_PIPE: out_s = line_r[depth_s];
            MODE_TIE0: out_s = {WIDTH{1'b0}};
            MODE_TIE1: out_s = {WIDTH{1'b1}};
            default:   out_s = {WIDTH{1'b0}};
         endcase
      end

      assign N_BEG[c*WIDTH +: WIDTH] = out_s;
   end

endmodule

// File: tb/tb_term_loopback_pipe.sv
// Scoreboard bench for term_loopback_pipe: a cycle-indexed reference model predicts every
// cycle's N_BEG and ConfigOut; a separate monitor compares them on the falling edge.
module tb_term_loopback_pipe;
   localparam int NUM_CH    = 4;
   localparam int WIDTH     = 16;
   localparam int MAX_DEPTH = 4;
   localparam int DW        = $clog2(MAX_DEPTH);
   localparam int F         = 2 + DW;
   localparam int L         = NUM_CH * F;
   localparam int HIST      = 4096;

   logic                    UserCLK;
   logic                    reset;
   logic                    ConfigEn;
   logic                    ConfigIn;
   logic                    ConfigLatch;
   logic                    ConfigOut;
   logic [NUM_CH*WIDTH-1:0] S_END;
   logic [NUM_CH*WIDTH-1:0] N_BEG;

   term_loopback_pipe #(
      .NUM_CH    (NUM_CH),
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH)
   ) dut (
      .UserCLK     (UserCLK),
      .reset       (reset),
      .ConfigEn    (ConfigEn),
      .ConfigIn    (ConfigIn),
      .ConfigLatch (ConfigLatch),
      .ConfigOut   (ConfigOut),
      .S_END       (S_END),
      .N_BEG       (N_BEG)
   );

   initial begin
      UserCLK = 1'b0;
      forever #5 UserCLK = ~UserCLK;
   end

   int errors = 0;
   int checks = 0;

   logic [NUM_CH*WIDTH-1:0] exp_q[$];
   logic                    exp_cfg_q[$];
   int                      exp_cyc_q[$];

   // Reference state: config vectors, a record of every reversed input by cycle, and the
   // last edge at which each channel's in-flight data was discarded.
   logic [L-1:0]     m_shadow;
   logic [L-1:0]     m_active;
   int               cyc;
   int               last_flush [NUM_CH];
   logic [WIDTH-1:0] in_hist [NUM_CH][HIST];

   function automatic logic [WIDTH-1:0] rev16(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
      return r;
   endfunction

   function automatic logic [F-1:0] fld(input int mode, input int depth);
      logic [F-1:0] r;
      r[1:0]   = mode[1:0];
      r[F-1:2] = depth[DW-1:0];
      return r;
   endfunction

   function automatic logic [L-1:0] cfg_of(input int m0, input int d0, input int m1, input int d1,
                                           input int m2, input int d2, input int m3, input int d3);
      return {fld(m3, d3), fld(m2, d2), fld(m1, d1), fld(m0, d0)};
   endfunction

   function automatic logic [NUM_CH*WIDTH-1:0] rand_s();
      logic [NUM_CH*WIDTH-1:0] r;
      logic [31:0] w;
      for (int c = 0; c < NUM_CH; c++) begin
         w = $urandom;
         r[c*WIDTH +: WIDTH] = w[WIDTH-1:0];
      end
      return r;
   endfunction

   // Expected output for the current cycle: PIPE with depth D shows the input of D+1 cycles
   // ago, unless that data was captured at or before the channel's last flush.
   function automatic logic [WIDTH-1:0] model_out(input int c);
      int mode;
      int depth;
      int src;
      logic [WIDTH-1:0] r;
      mode  = int'(m_active[c*F +: 2]);
      depth = int'(m_active[c*F+2 +: DW]);
      r = {WIDTH{1'b0}};
      case (mode)
         0: r = in_hist[c][cyc];
         1: begin
            src = cyc - 1 - depth;
            if (src > last_flush[c]) r = in_hist[c][src];
            else r = {WIDTH{1'b0}};
         end
         2: r = {WIDTH{1'b0}};
         default: r = {WIDTH{1'b1}};
      endcase
      return r;
   endfunction

   task automatic step(input logic [NUM_CH*WIDTH-1:0] s, input logic en, input logic din,
                       input logic latch, input logic rst, input bit chk);
      logic [NUM_CH*WIDTH-1:0] exp_n;
      logic [L-1:0] prev;
      S_END       = s;
      ConfigEn    = en;
      ConfigIn    = din;
      ConfigLatch = latch;
      reset       = rst;
      for (int c = 0; c < NUM_CH; c++) in_hist[c][cyc] = rev16(s[c*WIDTH +: WIDTH]);
      if (chk) begin
         for (int c = 0; c < NUM_CH; c++) exp_n[c*WIDTH +: WIDTH] = model_out(c);
         exp_q.push_back(exp_n);
         exp_cfg_q.push_back(m_shadow[0]);
         exp_cyc_q.push_back(cyc);
      end
      @(posedge UserCLK);
      if (rst) begin
         m_shadow = {L{1'b0}};
         m_active = {L{1'b0}};
         for (int c = 0; c < NUM_CH; c++) last_flush[c] = cyc;
      end else begin
         prev = m_shadow;
         if (en) m_shadow = {din, m_shadow[L-1:1]};
         if (latch) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (prev[c*F +: F] != m_active[c*F +: F]) last_flush[c] = cyc;
            end
            m_active = prev;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(rand_s(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic shift_bits(input logic [L-1:0] cfg, input int n);
      for (int i = 0; i < n; i++) step(rand_s(), 1'b1, cfg[i], 1'b0, 1'b0, 1'b1);
   endtask

   task automatic commit();
      step(rand_s(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   // Monitor: every falling edge with a pending expectation is one compared cycle.
   initial begin
      logic [NUM_CH*WIDTH-1:0] e;
      logic ec;
      int ecyc;
      forever begin
         @(negedge UserCLK);
         if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            ec   = exp_cfg_q.pop_front();
            ecyc = exp_cyc_q.pop_front();
            for (int c = 0; c < NUM_CH; c++) begin
               checks++;
               if (N_BEG[c*WIDTH +: WIDTH] !== e[c*WIDTH +: WIDTH]) begin
                  errors++;
                  $display("FAIL nbeg_ch%0d cyc=%0d got=%h exp=%h", c, ecyc,
                           N_BEG[c*WIDTH +: WIDTH], e[c*WIDTH +: WIDTH]);
               end
            end
            checks++;
            if (ConfigOut !== ec) begin
               errors++;
               $display("FAIL config_out cyc=%0d got=%b exp=%b", ecyc, ConfigOut, ec);
            end
         end
      end
   end

   initial begin
      logic [NUM_CH*WIDTH-1:0] s;
      logic [L-1:0] cfg;
      logic [31:0] w;
      m_shadow = {L{1'b0}};
      m_active = {L{1'b0}};
      cyc = 0;
      for (int c = 0; c < NUM_CH; c++) last_flush[c] = 0;

      // Reset, then the legacy combinational loopback.
      step(rand_s(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      s = rand_s();
      s[0 +: WIDTH] = 16'h0001;
      step(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run(4);

      // ch1 PIPE depth 2; 00F0 presented right after commit appears as 0F00 three cycles on.
      shift_bits(cfg_of(0, 0, 1, 2, 0, 0, 0, 0), L);
      commit();
      s = rand_s();
      s[WIDTH +: WIDTH] = 16'h00F0;
      step(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run(6);

      // ch2 TIE1, ch3 TIE0 while inputs keep toggling.
      shift_bits(cfg_of(0, 0, 1, 2, 3, 0, 2, 0), L);
      commit();
      run(6);

      // Shift without commit, then a commit in the same cycle as a shift.
      shift_bits(cfg_of(1, 3, 1, 1, 1, 0, 1, 3), L);
      run(4);
      shift_bits(cfg_of(3, 0, 2, 0, 3, 0, 2, 0), 5);
      step(rand_s(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      run(6);

      // ch1 depth 3 -> 0 with data in flight; ch0 stays PIPE depth 1 undisturbed.
      shift_bits(cfg_of(1, 1, 1, 3, 0, 0, 3, 0), L);
      commit();
      run(6);
      shift_bits(cfg_of(1, 1, 1, 0, 0, 0, 3, 0), L);
      commit();
      run(6);

      // Reset with pipelines full and a half-shifted shadow.
      w = $urandom;
      cfg = {w[15:0]};
      shift_bits(cfg, 7);
      step(rand_s(), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      run(8);

      // Randomised traffic with occasional commits and resets.
      for (int i = 0; i < 800; i++) begin
         step(rand_s(), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0), 1'b1);
      end

      @(negedge UserCLK);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/term_loopback_pipe.md
Name: term_loopback_pipe

Overview:
- Parametrised successor to the fixed terminal-tile loopback switch matrix.
- Returns NUM_CH wire groups, each WIDTH bits, from the incoming (S*END) side to the outgoing (N*BEG) side with bit-reversed ordering.
- Each channel has a serially configured mode: combinational, pipelined with programmable depth, or tied to a constant.
- Sits at the fabric edge in terminal tiles. Configuration goes through a shadow shift chain with an explicit commit.

Parameters:
- NUM_CH, 4, number of independent wire groups.
- WIDTH, 16, bits per group.
- MAX_DEPTH, 4, maximum pipeline latency in cycles (power of two, ≥2).
- DW, $clog2(MAX_DEPTH), depth field width (derived).
- F, 2+DW, config bits per channel (derived).
- L, NUM_CH*F, config chain length (derived).

Ports:
- UserCLK  in  1  fabric user clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ConfigEn  in  1  shift enable for the shadow config chain.
- ConfigIn  in  1  serial config data in.
- ConfigLatch  in  1  commit pulse: shadow chain to active config.
- ConfigOut  out  1  serial config data out (= shadow[0]), for daisy-chaining.
- S_END  in  NUM_CH*WIDTH  incoming wires; channel c = S_END[c*WIDTH +: WIDTH].
- N_BEG  out  NUM_CH*WIDTH  outgoing wires, same channel slicing.

Behaviour:
- Reset (reset=1 at an edge): shadow, active config and all delay-line registers go to 0. Result: all channels in COMB mode, ConfigOut=0, N_BEG = bit-reversed S_END. This matches the legacy fixed loopback.
- Shift: when ConfigEn=1, shadow <= {ConfigIn, shadow[L-1:1]}. ConfigOut follows the new shadow[0]. When ConfigEn=0, shadow holds.
- Field layout: channel c field = shadow[c*F +: F]. MODE = bits [1:0]; DEPTH = bits [F-1:2]. After L shifts, the first bit shifted in sits at bit 0 (channel 0 MODE lsb).
- Commit: when ConfigLatch=1, active <= shadow as it was before this edge. This holds even if ConfigEn=1 in the same cycle; the shift still happens.
- Commit flush: on commit, every channel whose MODE or DEPTH changes has its whole delay line cleared to 0 in the same edge. Unchanged channels are not disturbed.
- Reversal: rev(x)[i] = x[WIDTH-1-i], applied per channel.
- MODE 0 COMB: N_BEG_c = rev(S_END_c), combinational, zero latency. Delay line still clocks but is unused.
- MODE 1 PIPE: N_BEG_c = rev(S_END_c) delayed DEPTH+1 cycles (latency 1..MAX_DEPTH).
  - Implemented as a MAX_DEPTH-stage shift register; output tap = stage DEPTH.
  - After a flush, the output is 0 for DEPTH+1 cycles, then valid data.
- MODE 2 TIE0: N_BEG_c = all zeros.
- MODE 3 TIE1: N_BEG_c = all ones.
- Config changes take effect only at commit. Shifting alone never alters N_BEG.
- Output muxing is combinational from the active config and delay taps. In PIPE mode, N_BEG is driven directly from a register.
- reset asserted mid-shift or mid-pipeline: everything clears on that edge. Any partial shadow content is lost.
- reset has priority over ConfigEn and ConfigLatch in the same cycle.
- No X propagation: all registers are reset, and no latches are used.

Test Plan:
- Reset, then drive S_END ch0 = 16'h0001 -> N_BEG ch0 = 16'h8000 in the same cycle. All channels are reversed combinationally; ConfigOut=0.
- Shift 16 bits configuring ch1 = PIPE, DEPTH=2, then pulse ConfigLatch. Drive ch1 = 16'h00F0 at cycle t -> N_BEG ch1 = 16'h0F00 at t+3. Output is 0 at t+1 and t+2. Other channels remain COMB.
- Configure ch2 = TIE1 and ch3 = TIE0, commit -> ch2 = 16'hFFFF, ch3 = 16'h0000, regardless of S_END toggling.
- Shift a new pattern without ConfigLatch -> N_BEG unchanged. Same cycle ConfigEn=1 and ConfigLatch=1 -> active takes the pre-shift shadow value. ConfigOut emits the bits shifted in L cycles earlier.
- With ch1 in PIPE DEPTH=3 and data in flight, commit DEPTH=0 -> ch1 line flushed, 0 for 1 cycle, then 1-cycle latency. Ch0 (unchanged PIPE) keeps its in-flight data.
- Assert reset with a pipeline full and a half-shifted shadow -> next cycle all channels COMB reversed, ConfigOut=0, and no stale data appears later.
